id_stage_pipelined: RTL

Parametrised ARM-subset decode stage with an integrated register file and a registered ID/EX pipeline boundary. Each cycle it decodes one instruction from IF/ID, checks the condition field against the status register and reads operands, with optional same-cycle write-back bypass. It then loads an ID/EX register that supports stall (freeze), flush and hazard-bubble insertion. It sits between the IF/ID register and the EXE stage and feeds the hazard unit combinationally.

---
 rtl/id_stage_pipelined.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/id_stage_pipelined.sv
// id_stage_pipelined: ARM-subset decode with register file and ID/EX pipeline register.
// Define WB_BYPASS_EN so that same-cycle write-back data is forwarded to the operand reads.
module id_stage_pipelined #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 15,
  parameter int ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              valid_in,
  input  logic              freeze,
  input  logic              flush,
  input  logic              hazard,
  input  logic [3:0]        sr,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_value,
  output logic [ADDR_W-1:0] src1,
  output logic [ADDR_W-1:0] src2,
  output logic              two_src,
  output logic              valid_out,
  output logic              wb_en_out,
  output logic              mem_r_en_out,
  output logic              mem_w_en_out,
  output logic              b_out,
  output logic              s_out,
  output logic [3:0]        exe_cmd_out,
  output logic [DATA_W-1:0] val_rn_out,
  output logic [DATA_W-1:0] val_rm_out,
  output logic              imm_out,
  output logic [11:0]       shift_operand_out,
  output logic [23:0]       imm24_out,
  output logic [ADDR_W-1:0] dest_out,
  output logic [ADDR_W-1:0] src1_out,
  output logic [ADDR_W-1:0] src2_out,
  output logic [DATA_W-1:0] pc_out
);
  localparam logic [ADDR_W:0]   NR     = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] PC_IDX = ADDR_W'(15);

  typedef struct packed {
    logic              valid;
    logic              wb;
    logic              mr;
    logic              mw;
    logic              b;
    logic              s;
    logic [3:0]        cmd;
    logic [DATA_W-1:0] rn;
    logic [DATA_W-1:0] rm;
    logic              imm;
    logic [11:0]       shop;
    logic [23:0]       imm24;
    logic [ADDR_W-1:0] dest;
    logic [ADDR_W-1:0] s1;
    logic [ADDR_W-1:0] s2;
    logic [DATA_W-1:0] pc;
  } idex_t;

  logic [DATA_W-1:0] rf_q [NUM_REGS];
  idex_t             idex_q, idex_d, ld;
  logic              we, store, dec_ok, cond_ok, wb, mr, mw, br, sf;
  logic [3:0]        cmd;
  logic              in1, in2, hit1, hit2;
  logic [DATA_W-1:0] rd1, rd2;
  logic              n_f, z_f, c_f, v_f;

  assign {n_f, z_f, c_f, v_f} = sr;
  assign store   = instr_in[27:26] == 2'b01 && !instr_in[20];
  assign src1    = ADDR_W'(instr_in[19:16]);
  assign src2    = store ? ADDR_W'(instr_in[15:12]) : ADDR_W'(instr_in[3:0]);
  assign two_src = !instr_in[25] || store;

  // Register file: index 15 is the PC and is never stored
  assign we = wb_en && ({1'b0, wb_dest} < NR);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    else if (we) rf_q[wb_dest] <= wb_value;
  end

  assign in1 = {1'b0, src1} < NR;
  assign in2 = {1'b0, src2} < NR;
`ifdef WB_BYPASS_EN
  assign hit1 = wb_en && wb_dest == src1;
  assign hit2 = wb_en && wb_dest == src2;
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif
  assign rd1 = in1 ? (hit1 ? wb_value : rf_q[src1]) : src1 == PC_IDX ? pc_in : '0;
  assign rd2 = in2 ? (hit2 ? wb_value : rf_q[src2]) : src2 == PC_IDX ? pc_in : '0;

  always_comb begin
    case (instr_in[31:28])
      4'h0: cond_ok = z_f;
      4'h1: cond_ok = !z_f;
      4'h2: cond_ok = c_f;
      4'h3: cond_ok = !c_f;
      4'h4: cond_ok = n_f;
      4'h5: cond_ok = !n_f;
      4'h6: cond_ok = v_f;
      4'h7: cond_ok = !v_f;
      4'h8: cond_ok = c_f && !z_f;
      4'h9: cond_ok = !c_f || z_f;
      4'ha: cond_ok = n_f == v_f;
      4'hb: cond_ok = n_f != v_f;
      4'hc: cond_ok = !z_f && n_f == v_f;
      4'hd: cond_ok = z_f || n_f != v_f;
      4'he: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  always_comb begin
    dec_ok = 1'b0;
    cmd    = 4'b0000;
    wb     = 1'b0;
    mr     = 1'b0;
    mw     = 1'b0;
    br     = 1'b0;
    sf     = 1'b0;
    case (instr_in[27:26])
      2'b00: begin
        dec_ok = 1'b1;
        wb     = 1'b1;
        sf     = instr_in[20];
        case (instr_in[24:21])
          4'b1101: cmd = 4'b0001;
          4'b1111: cmd = 4'b1001;
          4'b0100: cmd = 4'b0010;
          4'b0101: cmd = 4'b0011;
          4'b0010: cmd = 4'b0100;
          4'b0110: cmd = 4'b0101;
          4'b0000: cmd = 4'b0110;
          4'b1100: cmd = 4'b0111;
          4'b0001: cmd = 4'b1000;
          4'b1010: begin cmd = 4'b0100; wb = 1'b0; end
          4'b1000: begin cmd = 4'b0110; wb = 1'b0; end
          default: begin dec_ok = 1'b0; wb = 1'b0; sf = 1'b0; end
        endcase
      end
      2'b01: begin
        dec_ok = 1'b1;
        cmd    = 4'b0010;
        sf     = instr_in[20];
        mr     = instr_in[20];
        wb     = instr_in[20];
        mw     = !instr_in[20];
      end
      2'b10: begin
        dec_ok = 1'b1;
        br     = 1'b1;
      end
      default: dec_ok = 1'b0;
    endcase
  end

  always_comb begin
    ld       = '0;
    ld.valid = 1'b1;
    ld.wb    = wb;
    ld.mr    = mr;
    ld.mw    = mw;
    ld.b     = br;
    ld.s     = sf;
    ld.cmd   = cmd;
    ld.rn    = rd1;
    ld.rm    = rd2;
    ld.imm   = instr_in[25];
    ld.shop  = instr_in[11:0];
    ld.imm24 = instr_in[23:0];
    ld.dest  = ADDR_W'(instr_in[15:12]);
    ld.s1    = src1;
    ld.s2    = src2;
    ld.pc    = pc_in;
    idex_d   = flush ? '0 : freeze ? idex_q :
               (hazard || !valid_in || !cond_ok || !dec_ok) ? '0 : ld;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idex_q <= '0;
    else idex_q <= idex_d;
  end

  assign valid_out         = idex_q.valid;
  assign wb_en_out         = idex_q.wb;
  assign mem_r_en_out      = idex_q.mr;
  assign mem_w_en_out      = idex_q.mw;
  assign b_out             = idex_q.b;
  assign s_out             = idex_q.s;
  assign exe_cmd_out       = idex_q.cmd;
  assign val_rn_out        = idex_q.rn;
  assign val_rm_out        = idex_q.rm;
  assign imm_out           = idex_q.imm;
  assign shift_operand_out = idex_q.shop;
  assign imm24_out         = idex_q.imm24;
  assign dest_out          = idex_q.dest;
  assign src1_out          = idex_q.s1;
  assign src2_out          = idex_q.s2;
  assign pc_out            = idex_q.pc;
endmodule
